// File: rtl/tow_match_scorer.sv
// Tug-of-war rope-light scorer with best-of match tracking, round hold and
// match-winner flash. All outputs come straight from registers.
module tow_match_scorer #(
  parameter int N_LEDS        = 7,
  parameter int ROUNDS_TO_WIN = 3,
  parameter int HOLD_CYCLES   = 256,
  parameter int FLASH_CYCLES  = 128
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 winrnd,
  input  logic                                 right,
  input  logic                                 tie,
  input  logic                                 leds_on,
  input  logic                                 penalty_en,
  output logic [N_LEDS-1:0]                    score,
  output logic [$clog2(ROUNDS_TO_WIN+1)-1:0]   left_rounds,
  output logic [$clog2(ROUNDS_TO_WIN+1)-1:0]   right_rounds,
  output logic                                 round_over,
  output logic                                 match_over,
  output logic                                 match_winner,
  output logic [1:0]                           state_dbg
);

  localparam int PW   = $clog2(N_LEDS);
  localparam int RW   = $clog2(ROUNDS_TO_WIN + 1);
  localparam int MAXC = (HOLD_CYCLES > FLASH_CYCLES) ? HOLD_CYCLES : FLASH_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [PW-1:0] CENTRE     = PW'((N_LEDS - 1) / 2);
  localparam logic [PW-1:0] LEFT_END   = PW'(N_LEDS - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] FLASH_LAST = CW'(FLASH_CYCLES - 1);
  localparam logic [RW-1:0] R_WIN      = RW'(ROUNDS_TO_WIN);
  localparam logic [N_LEDS-1:0] ONE    = N_LEDS'(1);

  typedef enum logic [1:0] {
    S_PLAY       = 2'd0,
    S_ROUND_WON  = 2'd1,
    S_MATCH_OVER = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [PW-1:0]   pos, pos_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            phase, phase_n;
  logic [RW-1:0]   lr_n, rr_n;
  logic            ro_n, winner_n;
  logic            step_up, step_dn;
  logic [N_LEDS-1:0] score_n;

  assign state_dbg = state;

  // winrnd is a one-cycle strobe; right/tie/leds_on/penalty_en only matter
  // in the cycle it is high. There is no back-pressure.
  always_comb begin
    state_n  = state;
    pos_n    = pos;
    cnt_n    = cnt;
    phase_n  = phase;
    lr_n     = left_rounds;
    rr_n     = right_rounds;
    ro_n     = 1'b0;
    winner_n = match_winner;
    step_up  = 1'b0;
    step_dn  = 1'b0;

    case (state)
      S_PLAY: begin
        if (winrnd && !tie) begin
          if (leds_on) begin
            step_dn = right;
            step_up = !right;
          end else if (penalty_en) begin
            // False start: the pusher loses ground instead of gaining it.
            step_up = right;
            step_dn = !right;
          end
        end
        if (step_up)      pos_n = pos + PW'(1);
        else if (step_dn) pos_n = pos - PW'(1);

        if (step_dn && pos_n == '0) begin
          rr_n    = right_rounds + RW'(1);
          ro_n    = 1'b1;
          cnt_n   = '0;
          phase_n = 1'b0;
          if (rr_n == R_WIN) begin
            state_n  = S_MATCH_OVER;
            winner_n = 1'b1;
          end else begin
            state_n  = S_ROUND_WON;
          end
        end else if (step_up && pos_n == LEFT_END) begin
          lr_n    = left_rounds + RW'(1);
          ro_n    = 1'b1;
          cnt_n   = '0;
          phase_n = 1'b0;
          if (lr_n == R_WIN) begin
            state_n  = S_MATCH_OVER;
            winner_n = 1'b0;
          end else begin
            state_n  = S_ROUND_WON;
          end
        end
      end
      S_ROUND_WON: begin
        if (cnt == HOLD_LAST) begin
          state_n = S_PLAY;
          pos_n   = CENTRE;
          cnt_n   = '0;
        end else begin
          cnt_n   = cnt + CW'(1);
        end
      end
      S_MATCH_OVER: begin
        if (cnt == FLASH_LAST) begin
          phase_n = ~phase;
          cnt_n   = '0;
        end else begin
          cnt_n   = cnt + CW'(1);
        end
      end
      default: state_n = S_PLAY;
    endcase

    // The end LED stays in pos during the hold and the flash, so one-hot(pos)
    // covers every case except the all-on flash phase.
    if (state_n == S_MATCH_OVER && phase_n) score_n = '1;
    else                                    score_n = ONE << pos_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_PLAY;
      pos          <= CENTRE;
      cnt          <= '0;
      phase        <= 1'b0;
      left_rounds  <= '0;
      right_rounds <= '0;
      round_over   <= 1'b0;
      match_over   <= 1'b0;
      match_winner <= 1'b0;
      score        <= ONE << CENTRE;
    end else begin
      state        <= state_n;
      pos          <= pos_n;
      cnt          <= cnt_n;
      phase        <= phase_n;
      left_rounds  <= lr_n;
      right_rounds <= rr_n;
      round_over   <= ro_n;
      match_over   <= (state_n == S_MATCH_OVER);
      match_winner <= winner_n;
      score        <= score_n;
    end
  end

endmodule

// File: doc/tow_match_scorer.md
# tow_match_scorer

Parametrised successor to the Tug-of-War scorer. It tracks the rope-light position across a configurable LED count, with optional false-start penalties. It also counts round wins per player into a best-of match, holding the winning LED between rounds and flashing the match winner at the end. It sits between the push-resolution / one-pulse path (`winrnd`, `right`, `tie`) and the LED multiplexer, and exports `round_over` to the master controller.

## Interface
Parameters:
- `N_LEDS`, 7: LED count; must be odd and ≥3. Centre index `C = (N_LEDS-1)/2`.
- `ROUNDS_TO_WIN`, 3: round wins needed to take the match; ≥1.
- `HOLD_CYCLES`, 256: cycles the round-winning LED is held before re-centring; ≥1.
- `FLASH_CYCLES`, 128: half-period of the match-winner flash; ≥1.

Ports:
- `clk`  in  1: the single clock.
- `rst`  in  1: synchronous, active-high reset.
- `winrnd`  in  1: single-cycle pulse, meaning a push was resolved this cycle.
- `right`  in  1: qualifies `winrnd`. 1 = right player pushed first; 0 = left.
- `tie`  in  1: qualifies `winrnd`. Both players pushed together.
- `leds_on`  in  1: the go-LED was lit when the push occurred.
- `penalty_en`  in  1: mode select. 1 = penalise false starts; 0 = ignore pushes while `leds_on`=0.
- `score`  out  N_LEDS: LED pattern. Bit 0 is the right end and bit N_LEDS-1 is the left end.
- `left_rounds`, `right_rounds`  out  $clog2(ROUNDS_TO_WIN+1): rounds won by each player.
- `round_over`  out  1: one-cycle pulse when a round is won.
- `match_over`  out  1: level; high once the match is decided.
- `match_winner`  out  1: 1 = right player, 0 = left. Valid only while `match_over`=1.

## Operation
- Internal state: position `pos` in 0..N_LEDS-1; FSM {PLAY, ROUND_WON, MATCH_OVER}; hold/flash counter; flash phase bit.
- Reset values: `pos`=C, state PLAY, `score`=one-hot(C), both round counters 0, `round_over`=0, `match_over`=0, `match_winner`=0, counters 0.
- PLAY: `score` = one-hot(`pos`). An event is `winrnd`=1 and `tie`=0; `tie` always dominates and causes no move.
  - `leds_on`=1: the pusher gains. `right`=1 gives `pos`-1; `right`=0 gives `pos`+1.
  - `leds_on`=0 with `penalty_en`=1: false start, so the pusher loses. `right`=1 gives `pos`+1; `right`=0 gives `pos`-1.
  - `leds_on`=0 with `penalty_en`=0: no move.
- Round end: `pos` reaching 0 is a right round win; reaching N_LEDS-1 is a left round win.
  - In the same update, the winner's counter increments and `round_over` pulses.
  - If the new count equals ROUNDS_TO_WIN, go to MATCH_OVER and latch `match_winner`. Otherwise go to ROUND_WON.
- ROUND_WON: `score` holds the end LED and `winrnd` is ignored. After HOLD_CYCLES, `pos` returns to C and the FSM returns to PLAY.
- MATCH_OVER: `match_over`=1 and `winrnd` is ignored.
  - `score` alternates between the winner's end LED (phase 0) and all ones (phase 1), toggling every FLASH_CYCLES.
  - The FSM stays in MATCH_OVER until `rst`.
- Arithmetic: `pos` never leaves 0..N_LEDS-1, because reaching an end always exits PLAY. The round counters never exceed ROUNDS_TO_WIN.

## Timing
- All outputs are registered. An event sampled at edge t is reflected in `score` and the counters after edge t.
- `round_over` is high for exactly the one cycle after the winning edge, never longer.
- ROUND_WON lasts exactly HOLD_CYCLES cycles. The first PLAY cycle with `score`=one-hot(C) is HOLD_CYCLES cycles after the winning update, and a `winrnd` in that cycle is accepted.
- Flash: the first phase-0 period (end LED only) starts in the cycle `match_over` rises. Each phase lasts exactly FLASH_CYCLES cycles.
- Qualifiers (`right`, `tie`, `leds_on`, `penalty_en`) are sampled only in cycles where `winrnd`=1.
- `rst` mid-operation (any state, any counter value) returns every output to its reset value on that edge. `rst` overrides a simultaneous `winrnd`.

## Test plan
- Reset, then `winrnd`,`right`=1,`leds_on`=1 -> `score` goes 7'b0001000 to 7'b0000100 the next cycle. A following `tie`=1 push leaves it unchanged.
- From centre, three right pushes with `leds_on`=1 -> `score`=7'b0000001, one-cycle `round_over`, `right_rounds`=1. A `winrnd` during the hold is ignored. After 256 cycles, `score`=7'b0001000.
- `leds_on`=0, `right`=1, `penalty_en`=1 -> `score`=7'b0010000. Same push with `penalty_en`=0 -> `score` unchanged.
- Right wins three rounds -> `match_over`=1, `match_winner`=1, `score` alternates 7'b0000001 / 7'b1111111 every 128 cycles, and further `winrnd` pulses are ignored.
- Left player reaches 7'b1000000 twice -> `left_rounds`=2. Assert `rst` during the hold -> all outputs at reset values after that edge, with no re-centre glitch later.
- Sweep N_LEDS=3 and ROUNDS_TO_WIN=1 -> a single push from centre wins the round and immediately asserts `match_over`.
